// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-bus signal bundle for mem_bus_arbiter.
// slave  : the arbiter's view (serves IF/MEM requesters, drives the bus).
// master : the environment's view (requesters plus bus responder).
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  // Requester side
  logic                  global_flush;
  logic                  inst_req;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic [DATA_WIDTH-1:0] inst_data;
  logic                  inst_ready;
  logic                  inst_stall;
  logic                  data_enable;
  logic                  data_rw;
  logic [3:0]            data_sel;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [DATA_WIDTH-1:0] data_write;
  logic [DATA_WIDTH-1:0] data_read;
  logic                  data_ready;
  logic                  data_stall;
  logic                  bus_error;

  // Memory bus side
  logic                  bus_req;
  logic                  bus_rw;
  logic [3:0]            bus_sel;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_ack;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport slave (
    input  global_flush, inst_req, inst_addr,
    input  data_enable, data_rw, data_sel, data_addr, data_write,
    input  bus_ack, bus_rdata,
    output inst_data, inst_ready, inst_stall,
    output data_read, data_ready, data_stall, bus_error,
    output bus_req, bus_rw, bus_sel, bus_addr, bus_wdata
  );

  modport master (
    output global_flush, inst_req, inst_addr,
    output data_enable, data_rw, data_sel, data_addr, data_write,
    output bus_ack, bus_rdata,
    input  inst_data, inst_ready, inst_stall,
    input  data_read, data_ready, data_stall, bus_error,
    input  bus_req, bus_rw, bus_sel, bus_addr, bus_wdata
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one req/ack memory bus between instruction fetch and MEM-stage data
// access. Round-robin on contention, per-transaction timeout, fetch squash on
// global_flush, one-cycle RESP slot after every completion.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_bus_arbiter_if.slave bus_if
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic GRANT_DATA = 1'b0;
  localparam logic GRANT_INST = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_INST = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  squash_q, squash_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_rw_q, bus_rw_d;
  logic [3:0]            bus_sel_q, bus_sel_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_WIDTH-1:0] inst_data_q, inst_data_d;
  logic                  inst_ready_q, inst_ready_d;
  logic [DATA_WIDTH-1:0] data_read_q, data_read_d;
  logic                  data_ready_q, data_ready_d;
  logic                  bus_error_q, bus_error_d;

  logic data_cand_c, inst_cand_c;
  logic grant_data_c, grant_inst_c;
  logic ack_c, timeout_c, done_c, squash_now_c;

  // Grant decision: opposite of last_grant when both candidates are present
  assign data_cand_c  = bus_if.data_enable;
  assign inst_cand_c  = bus_if.inst_req & ~bus_if.global_flush;
  assign grant_data_c = (state_q == S_IDLE) & data_cand_c &
                        (~inst_cand_c | (last_grant_q == GRANT_INST));
  assign grant_inst_c = (state_q == S_IDLE) & inst_cand_c &
                        (~data_cand_c | (last_grant_q == GRANT_DATA));

  // Transaction end: ack only counts while a request is outstanding
  assign ack_c        = bus_if.bus_ack & bus_req_q;
  assign timeout_c    = bus_req_q & ~ack_c & (cnt_q == TIMEOUT_LAST);
  assign done_c       = ack_c | timeout_c;
  assign squash_now_c = squash_q | bus_if.global_flush;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_INST;
      cnt_q        <= '0;
      squash_q     <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_rw_q     <= 1'b0;
      bus_sel_q    <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      inst_data_q  <= '0;
      inst_ready_q <= 1'b0;
      data_read_q  <= '0;
      data_ready_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      squash_q     <= squash_d;
      bus_req_q    <= bus_req_d;
      bus_rw_q     <= bus_rw_d;
      bus_sel_q    <= bus_sel_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      inst_data_q  <= inst_data_d;
      inst_ready_q <= inst_ready_d;
      data_read_q  <= data_read_d;
      data_ready_q <= data_ready_d;
      bus_error_q  <= bus_error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_data_c) begin
          state_d = S_DATA;
        end else if (grant_inst_c) begin
          state_d = S_INST;
        end
      end
      S_DATA, S_INST: begin
        if (done_c) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    squash_d     = squash_q;
    bus_req_d    = bus_req_q;
    bus_rw_d     = bus_rw_q;
    bus_sel_d    = bus_sel_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    inst_data_d  = inst_data_q;
    inst_ready_d = 1'b0;
    data_read_d  = data_read_q;
    data_ready_d = 1'b0;
    bus_error_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_data_c) begin
          bus_req_d    = 1'b1;
          bus_rw_d     = bus_if.data_rw;
          bus_sel_d    = bus_if.data_sel;
          bus_addr_d   = bus_if.data_addr;
          bus_wdata_d  = bus_if.data_rw ? bus_if.data_write : '0;
          last_grant_d = GRANT_DATA;
          cnt_d        = '0;
        end else if (grant_inst_c) begin
          bus_req_d    = 1'b1;
          bus_rw_d     = 1'b0;
          bus_sel_d    = 4'b1111;
          bus_addr_d   = bus_if.inst_addr;
          bus_wdata_d  = '0;
          last_grant_d = GRANT_INST;
          cnt_d        = '0;
        end
      end
      S_DATA: begin
        if (done_c) begin
          bus_req_d    = 1'b0;
          data_ready_d = 1'b1;
          bus_error_d  = timeout_c;
          if (!bus_rw_q) begin
            data_read_d = ack_c ? bus_if.bus_rdata : '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_INST: begin
        // A flushed fetch still finishes on the bus but never reaches IF
        squash_d = squash_now_c;
        if (done_c) begin
          bus_req_d = 1'b0;
          if (!squash_now_c) begin
            inst_ready_d = 1'b1;
            bus_error_d  = timeout_c;
            inst_data_d  = ack_c ? bus_if.bus_rdata : '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        squash_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Stalls are combinational so the hazard unit sees them in the request cycle
  assign bus_if.inst_stall = bus_if.inst_req & ~inst_ready_q;
  assign bus_if.data_stall = bus_if.data_enable & ~data_ready_q;

  assign bus_if.inst_data  = inst_data_q;
  assign bus_if.inst_ready = inst_ready_q;
  assign bus_if.data_read  = data_read_q;
  assign bus_if.data_ready = data_ready_q;
  assign bus_if.bus_error  = bus_error_q;
  assign bus_if.bus_req    = bus_req_q;
  assign bus_if.bus_rw     = bus_rw_q;
  assign bus_if.bus_sel    = bus_sel_q;
  assign bus_if.bus_addr   = bus_addr_q;
  assign bus_if.bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected completions,
// a negedge monitor pops them whenever a ready pulse appears.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  mem_bus_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_if(bif)
  );

  typedef struct {
    bit          is_inst;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Bus responder configuration (written by stimulus only)
  int          rsp_delay   = 0;
  bit          rsp_never   = 1'b0;
  bit          rsp_by_addr = 1'b0;
  logic [31:0] rsp_data    = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus slave: acks rsp_delay cycles after bus_req rises, or never
  initial begin
    int wait_cnt;
    wait_cnt      = 0;
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bif.bus_req) begin
        if (!rsp_never && wait_cnt == rsp_delay) begin
          bif.bus_ack   = 1'b1;
          bif.bus_rdata = rsp_by_addr ? {bif.bus_addr[15:0], 16'hC0DE} : rsp_data;
        end else begin
          bif.bus_ack   = 1'b0;
          bif.bus_rdata = '0;
        end
        wait_cnt++;
      end else begin
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = '0;
        wait_cnt      = 0;
      end
    end
  end

  // Monitor: every ready pulse must match the oldest expected completion
  always @(negedge clk) begin
    if (rst_n && (bif.data_ready || bif.inst_ready)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got data_ready=%0b inst_ready=%0b want no pulse at %0t",
                 bif.data_ready, bif.inst_ready, $time);
      end else begin
        mon_e = sb.pop_front();
        check("ready_kind", {30'd0, bif.inst_ready, bif.data_ready},
              mon_e.is_inst ? 32'd2 : 32'd1);
        check(mon_e.is_inst ? "inst_data" : "data_read",
              mon_e.is_inst ? bif.inst_data : bif.data_read, mon_e.data);
        check("bus_error", {31'd0, bif.bus_error}, {31'd0, mon_e.err});
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test want finish before 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n            = 1'b0;
    bif.global_flush = 1'b0;
    bif.inst_req     = 1'b0;
    bif.inst_addr    = '0;
    bif.data_enable  = 1'b0;
    bif.data_rw      = 1'b0;
    bif.data_sel     = 4'h0;
    bif.data_addr    = '0;
    bif.data_write   = '0;
    repeat (2) tick();

    // Reset state
    check("rst_bus_req",    {31'd0, bif.bus_req},    32'd0);
    check("rst_bus_sel",    {28'd0, bif.bus_sel},    32'd0);
    check("rst_bus_addr",   bif.bus_addr,            32'd0);
    check("rst_inst_data",  bif.inst_data,           32'd0);
    check("rst_data_ready", {31'd0, bif.data_ready}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single read with zero-wait ack
    rsp_delay       = 0;
    rsp_data        = 32'hDEADBEEF;
    bif.data_enable = 1'b1;
    bif.data_rw     = 1'b0;
    bif.data_sel    = 4'hF;
    bif.data_addr   = 32'h100;
    bif.data_write  = 32'h55;
    sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
    #1 check("t1_stall_c0", {31'd0, bif.data_stall}, 32'd1);
    tick();
    check("t1_bus_req_c1",   {31'd0, bif.bus_req}, 32'd1);
    check("t1_bus_addr_c1",  bif.bus_addr,         32'h100);
    check("t1_bus_wdata_c1", bif.bus_wdata,        32'd0);
    check("t1_bus_sel_c1",   {28'd0, bif.bus_sel}, 32'hF);
    tick();
    check("t1_ready_c2", {31'd0, bif.data_ready}, 32'd1);
    check("t1_stall_c2", {31'd0, bif.data_stall}, 32'd0);
    bif.data_enable = 1'b0;
    tick();
    check("t1_ready_c3", {31'd0, bif.data_ready}, 32'd0);

    // Store with three wait cycles; data_read must keep 0xDEADBEEF
    rsp_delay       = 3;
    bif.data_enable = 1'b1;
    bif.data_rw     = 1'b1;
    bif.data_sel    = 4'b0011;
    bif.data_addr   = 32'h104;
    bif.data_write  = 32'h0000ABCD;
    sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("t2_req_c%0d", i),   {31'd0, bif.bus_req}, 32'd1);
      check($sformatf("t2_sel_c%0d", i),   {28'd0, bif.bus_sel}, 32'h3);
      check($sformatf("t2_wdata_c%0d", i), bif.bus_wdata,        32'h0000ABCD);
    end
    tick();
    check("t2_ready", {31'd0, bif.data_ready}, 32'd1);
    bif.data_enable = 1'b0;
    tick();
    check("t2_ready_once", {31'd0, bif.data_ready}, 32'd0);

    // Timeout: no ack at all
    rsp_never       = 1'b1;
    bif.data_enable = 1'b1;
    bif.data_rw     = 1'b0;
    bif.data_sel    = 4'hF;
    bif.data_addr   = 32'h108;
    sb.push_back('{1'b0, 32'h0, 1'b1});
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("t3_req_c%0d", i), {31'd0, bif.bus_req}, 32'd1);
    end
    tick();
    check("t3_req_dropped", {31'd0, bif.bus_req},   32'd0);
    check("t3_ready",       {31'd0, bif.data_ready}, 32'd1);
    check("t3_error",       {31'd0, bif.bus_error},  32'd1);
    bif.data_enable = 1'b0;
    rsp_never       = 1'b0;
    tick();
    check("t3_error_once", {31'd0, bif.bus_error}, 32'd0);

    // Fetch establishing inst_data = 0x11112222
    rsp_delay     = 0;
    rsp_data      = 32'h11112222;
    bif.inst_req  = 1'b1;
    bif.inst_addr = 32'h200;
    sb.push_back('{1'b1, 32'h11112222, 1'b0});
    tick();
    tick();
    check("t4a_ready", {31'd0, bif.inst_ready}, 32'd1);
    check("t4a_stall", {31'd0, bif.inst_stall}, 32'd0);
    bif.inst_req = 1'b0;
    tick();

    // Fetch flushed in flight, ack arrives two cycles after the flush
    rsp_delay     = 2;
    rsp_data      = 32'h12345678;
    bif.inst_req  = 1'b1;
    bif.inst_addr = 32'h204;
    tick();
    check("t4b_bus_addr", bif.bus_addr,         32'h204);
    check("t4b_bus_sel",  {28'd0, bif.bus_sel}, 32'hF);
    bif.global_flush = 1'b1;
    bif.inst_req     = 1'b0;
    tick();
    bif.global_flush = 1'b0;
    check("t4b_req_held", {31'd0, bif.bus_req}, 32'd1);
    tick();
    tick();
    check("t4b_no_ready",  {31'd0, bif.inst_ready}, 32'd0);
    check("t4b_inst_data", bif.inst_data,           32'h11112222);
    check("t4b_req_done",  {31'd0, bif.bus_req},    32'd0);
    tick();

    // Flush in IDLE blocks the grant for that cycle only; then a normal fetch
    rsp_delay        = 0;
    rsp_data         = 32'h9ABCDEF0;
    bif.inst_req     = 1'b1;
    bif.inst_addr    = 32'h208;
    bif.global_flush = 1'b1;
    sb.push_back('{1'b1, 32'h9ABCDEF0, 1'b0});
    tick();
    check("t4c_blocked", {31'd0, bif.bus_req}, 32'd0);
    bif.global_flush = 1'b0;
    tick();
    check("t4c_req",  {31'd0, bif.bus_req}, 32'd1);
    check("t4c_addr", bif.bus_addr,         32'h208);
    tick();
    check("t4c_ready", {31'd0, bif.inst_ready}, 32'd1);
    bif.inst_req = 1'b0;
    tick();

    // Reset while a transaction is outstanding
    rsp_never       = 1'b1;
    bif.data_enable = 1'b1;
    bif.data_rw     = 1'b0;
    bif.data_sel    = 4'hF;
    bif.data_addr   = 32'h10C;
    tick();
    tick();
    check("t5_req_before", {31'd0, bif.bus_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_req_async",   {31'd0, bif.bus_req}, 32'd0);
    check("t5_addr_async",  bif.bus_addr,         32'd0);
    check("t5_inst_data",   bif.inst_data,        32'd0);
    bif.data_enable = 1'b0;
    rsp_never       = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rsp_data        = 32'hCAFEF00D;
    bif.data_enable = 1'b1;
    bif.data_addr   = 32'h110;
    sb.push_back('{1'b0, 32'hCAFEF00D, 1'b0});
    tick();
    check("t5_fresh_req",  {31'd0, bif.bus_req}, 32'd1);
    check("t5_fresh_addr", bif.bus_addr,         32'h110);
    tick();
    check("t5_fresh_ready", {31'd0, bif.data_ready}, 32'd1);
    bif.data_enable = 1'b0;
    tick();

    // Contention from reset: DATA, INST, DATA, INST
    rst_n           = 1'b0;
    rsp_by_addr     = 1'b1;
    rsp_delay       = 0;
    bif.inst_req    = 1'b1;
    bif.inst_addr   = 32'h200;
    bif.data_enable = 1'b1;
    bif.data_rw     = 1'b0;
    bif.data_sel    = 4'hF;
    bif.data_addr   = 32'h300;
    sb.push_back('{1'b0, 32'h0300C0DE, 1'b0});
    sb.push_back('{1'b1, 32'h0200C0DE, 1'b0});
    sb.push_back('{1'b0, 32'h0300C0DE, 1'b0});
    sb.push_back('{1'b1, 32'h0200C0DE, 1'b0});
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      if (bif.data_ready || bif.inst_ready) begin
        n++;
        if (n == 4) begin
          bif.inst_req    = 1'b0;
          bif.data_enable = 1'b0;
        end
      end
    end
    bif.inst_req    = 1'b0;
    bif.data_enable = 1'b0;
    check("t6_completions", n, 32'd4);
    repeat (3) tick();
    check("t6_bus_idle", {31'd0, bif.bus_req}, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external memory bus between instruction fetch (IF) and data access (MEM stage) using a req/ack handshake.
- Presents the bus to each requester as a simple request/ready interface and produces the per-requester stall signals used by the hazard unit.
- Sits between the IF stage and the MEM-stage load/store formatting logic on one side, and the unified memory/peripheral bus on the other.
- Bus-side outputs are registered; the arbiter has no knowledge of instruction types.

Parameters:
- ADDR_WIDTH, 32, width of byte addresses.
- DATA_WIDTH, 32, width of bus data.
- TIMEOUT_CYCLES, 255, number of cycles to wait for bus_ack before aborting (1..255).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- global_flush  in  1  squashes any in-flight or pending instruction fetch.
- inst_req  in  1  IF requests a read at inst_addr.
- inst_addr  in  ADDR_WIDTH  fetch address.
- inst_data  out  DATA_WIDTH  fetched word; holds until the next inst completion.
- inst_ready  out  1  one-cycle pulse: inst_data valid.
- inst_stall  out  1  combinational: inst_req && !inst_ready.
- data_enable  in  1  MEM-stage access request.
- data_rw  in  1  0 = read, 1 = write (MEM_READ / MEM_WRITE encoding).
- data_sel  in  4  byte lanes, bit 3 = bits [31:24].
- data_addr  in  ADDR_WIDTH  access address.
- data_write  in  DATA_WIDTH  pre-aligned store data.
- data_read  out  DATA_WIDTH  raw read word; holds until the next data read completion.
- data_ready  out  1  one-cycle pulse: data access complete.
- data_stall  out  1  combinational: data_enable && !data_ready.
- bus_error  out  1  one-cycle pulse alongside the ready pulse when the transaction timed out.
- bus_req  out  1  bus request, held until ack or timeout.
- bus_rw  out  1  bus direction.
- bus_sel  out  4  bus byte enables; 4'b1111 for fetches.
- bus_addr  out  ADDR_WIDTH  bus address.
- bus_wdata  out  DATA_WIDTH  bus write data; 0 for reads.
- bus_ack  in  1  bus completion, sampled only while bus_req = 1.
- bus_rdata  in  DATA_WIDTH  valid in the cycle bus_ack = 1.

Behaviour:
- Reset (asynchronous, immediate): every registered output is 0, including bus_req, bus_rw, bus_sel, bus_addr, bus_wdata, inst_data, inst_ready, data_read, data_ready and bus_error. State = IDLE, last_grant = INST, timeout counter = 0, squash flag = 0. A bus transaction in progress is abandoned without completion.
- States: IDLE, DATA, INST, RESP.
- IDLE:
  - Sample requests. Candidate data = data_enable; candidate inst = inst_req && !global_flush.
  - Both candidates present: grant the one opposite to last_grant.
  - One candidate: grant it.
  - On grant: register bus_* from the winner's inputs, set bus_req = 1, update last_grant, clear the counter, enter DATA or INST.
  - No candidate: stay in IDLE.
- DATA / INST:
  - Bus outputs are held stable.
  - bus_ack = 1:
    - bus_req <= 0.
    - Latch bus_rdata into data_read (data reads only) or inst_data.
    - Enter RESP with the matching ready pulse scheduled.
  - No ack: counter increments.
  - Counter == TIMEOUT_CYCLES-1 without ack:
    - bus_req <= 0.
    - Latched read word forced to 0.
    - bus_error pulses with the ready.
    - Enter RESP.
- RESP (exactly 1 cycle):
  - data_ready or inst_ready is high for this cycle only.
  - No new grant is made, so the requester can advance before being re-sampled.
  - Next state: IDLE.
- Latency with zero-wait ack: request seen in IDLE at cycle 0 → bus_req high at cycle 1 → ack in cycle 1 → ready at cycle 2. Earliest next grant is at cycle 3.
- global_flush:
  - During INST: set the squash flag. The transaction still completes on the bus, but inst_ready and inst_data updates are suppressed. The flag clears on leaving RESP.
  - In IDLE: blocks an inst grant in that cycle.
  - DATA transactions are never affected.
- A write completion pulses data_ready and leaves data_read unchanged.
- Requesters must present stable inputs while their stall is high, and must consume the ready pulse in that cycle.
- bus_ack while bus_req = 0 is ignored.

Test Plan:
- Single read: data_enable=1, rw=0, addr=0x100, ack in the first bus cycle with rdata=0xDEADBEEF → bus_req high cycle 1; data_ready and data_read=0xDEADBEEF at cycle 2; data_stall low at cycle 2.
- Contention: inst_req and data_enable both held from reset → grants in order DATA, INST, DATA, INST (last_grant reset = INST). Each completion is followed by one RESP cycle.
- Store: rw=1, sel=4'b0011, wdata=0x0000ABCD, ack after 3 wait cycles → bus_sel/bus_wdata stable for 4 cycles; data_ready pulses once; data_read unchanged.
- Timeout: TIMEOUT_CYCLES=4, never ack → bus_req drops after 4 cycles; data_ready and bus_error pulse together; data_read=0.
- Flush: global_flush during INST, ack 2 cycles later with 0x12345678 → no inst_ready; inst_data keeps its old value; next fetch proceeds normally.
- Reset mid-transaction: rst_n low while bus_req=1 → bus_req=0 immediately; after release, state is IDLE and a fresh read completes normally.
